q3_mux_scan_ctrl: RTL and testbench

- Sequential driver/checker directly upstream of the 16-to-1 mux (q3_mux16to1).
- Latches a 16-bit word onto the mux data inputs, sweeps the 4-bit select 0..15 one step per clock, and samples the mux output back into a capture register.
- Reports the reassembled word and a match flag, giving a self-checking scan of the mux datapath.

---
 rtl/q3_scan_pkg.sv | 13 +
 rtl/q3_mux_scan_ctrl_sel_counter.sv | 36 +++
 rtl/q3_mux_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_q3_mux_scan_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/q3_scan_pkg.sv
// Shared types and sizing for the q3 mux scan controller.
package q3_scan_pkg;

    localparam int unsigned MUX_WIDTH = 16;
    localparam int unsigned MUX_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/q3_mux_scan_ctrl_sel_counter.sv
// Select counter for the mux scan: synchronous load-zero, count enable, terminal count.
module q3_sel_counter #(
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] cnt,
    output logic             tc_c
);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc_c = (cnt_q == {SEL_W{1'b1}});

endmodule

// File: rtl/q3_mux_scan_ctrl.sv
// Drives a word and a select sweep into a 16:1 mux and reassembles its output for comparison.
// Optional parity check of the sampled stream: define MUX_SCAN_PARITY_EN.
module q3_mux_scan_ctrl
    import q3_scan_pkg::*;
#(
    parameter int unsigned WIDTH = MUX_WIDTH,
    parameter int unsigned SEL_W = MUX_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mux_in,
    output logic [WIDTH-1:0] aa_out,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cap_word,
    output logic             match
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    scan_state_t      state_q, state_d;
    logic [WIDTH-1:0] aa_q, aa_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             match_q, match_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_en;
    logic             sel_tc_c;
    logic [SEL_W-1:0] sel_cnt;
`ifdef MUX_SCAN_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    q3_sel_counter #(.SEL_W(SEL_W)) u_sel_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (sel_cnt),
        .tc_c  (sel_tc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (sel_tc_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; mux_in is sampled a full cycle after sel settles.
    always_comb begin
        aa_d    = aa_q;
        cap_d   = cap_q;
        match_d = match_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    aa_d    = data_in;
                    cap_d   = '0;
                    match_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_clr = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
`endif
                end
            end
            SCAN: begin
                cap_d[sel_cnt] = mux_in;
                cnt_en         = !sel_tc_c;
`ifdef MUX_SCAN_PARITY_EN
                par_d          = par_q ^ mux_in;
`endif
                if (sel_tc_c) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            DONE: begin
                match_d = (cap_q == aa_q);
`ifdef MUX_SCAN_PARITY_EN
                perr_d  = (par_q != (^aa_q));
`endif
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aa_q    <= '0;
            cap_q   <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            aa_q    <= aa_d;
            cap_q   <= cap_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MUX_SCAN_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign aa_out   = aa_q;
    assign sel      = sel_cnt;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cap_word = cap_q;
    assign match    = match_q;
`ifdef MUX_SCAN_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_q3_mux_scan_ctrl.sv
// Directed bench for q3_mux_scan_ctrl with a behavioural 16:1 mux in the loop.
module tb_q3_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic        mux_in;
    logic [15:0] aa_out;
    logic [3:0]  sel;
    logic        busy;
    logic        done;
    logic [15:0] cap_word;
    logic        match;
    logic        force_zero = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    logic        parity_err;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Healthy mux, optionally stuck at zero for fault injection.
    assign mux_in = force_zero ? 1'b0 : aa_out[sel];

    q3_mux_scan_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .mux_in   (mux_in),
        .aa_out   (aa_out),
        .sel      (sel),
        .busy     (busy),
        .done     (done),
        .cap_word (cap_word),
        .match    (match)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full scan: start raised after an edge, accepted on the next one.
    task automatic run_scan(input string tag, input logic [15:0] d, input logic [15:0] exp_cap,
                            input logic exp_match, input logic exp_perr, input logic poke_data);
        logic sel_ok;
        logic early_done;
        sel_ok = 1'b1;
        early_done = 1'b0;
        start = 1'b1;
        data_in = d;
        tick();
        start = 1'b0;
        chk({tag, "_accept"}, {busy, done, sel, aa_out}, {1'b1, 1'b0, 4'd0, d});
        for (int i = 1; i <= 15; i++) begin
            if (poke_data) data_in = ~d;
            tick();
            if (sel !== 4'(i) || busy !== 1'b1) sel_ok = 1'b0;
            if (done !== 1'b0) early_done = 1'b1;
        end
        chk({tag, "_sweep"}, {sel_ok, early_done}, {1'b1, 1'b0});
        tick();
        chk({tag, "_done"}, {done, busy, sel, cap_word}, {1'b1, 1'b0, 4'd15, exp_cap});
        tick();
        chk({tag, "_result"}, {done, busy, sel, aa_out, match}, {1'b0, 1'b0, 4'd15, d, exp_match});
`ifdef MUX_SCAN_PARITY_EN
        chk({tag, "_parity"}, {31'd0, parity_err}, {31'd0, exp_perr});
`else
        if (exp_perr === 1'bx) chk({tag, "_perr_arg"}, 32'd0, 32'd1);
`endif
        tick();
        chk({tag, "_hold"}, {done, sel, cap_word, match}, {1'b0, 4'd15, exp_cap, exp_match});
    endtask

    initial begin
        int ndone;
        int first_at;
        int second_at;
        int third_at;

        #2;
        chk("reset_async", {aa_out, sel, busy, done, cap_word, match},
            {16'd0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0});
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_hold", {16'd0, busy, done, sel, match}, {16'd0, 1'b0, 1'b0, 4'd0, 1'b0});

        run_scan("zero", 16'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_scan("d64", 16'd64, 16'h0040, 1'b1, 1'b0, 1'b1);
        run_scan("fffe", 16'd65534, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        run_scan("a023", 16'hA023, 16'hA023, 1'b1, 1'b0, 1'b0);

        force_zero = 1'b1;
        run_scan("stuck0", 16'd16384, 16'h0000, 1'b0, 1'b1, 1'b0);
        force_zero = 1'b0;

        // Extra start inside SCAN must not queue a second scan.
        start = 1'b1;
        data_in = 16'h1234;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5 || i == 16) start = 1'b1;
            else start = 1'b0;
            tick();
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        chk("restart_ignored", 32'(ndone), 32'd1);
        chk("restart_result", {cap_word, match}, {16'h1234, 1'b1});

        // Reset mid-scan when sel reaches 7.
        start = 1'b1;
        data_in = 16'hBEEF;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("pre_abort_sel", {28'd0, sel}, 32'd7);
        rst_n = 1'b0;
        #1;
        chk("abort_clear", {aa_out, sel, busy, done, cap_word, match},
            {16'd0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0});
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Start held high: scans repeat every 18 edges.
        start = 1'b1;
        data_in = 16'h5A5A;
        ndone = 0;
        first_at = -1;
        second_at = -1;
        third_at = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) first_at = i;
                if (ndone == 2) second_at = i;
                if (ndone == 3) third_at = i;
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(ndone), 32'd3);
        chk("b2b_first", 32'(first_at), 32'd17);
        chk("b2b_gap", {16'(second_at - first_at), 16'(third_at - second_at)}, {16'd18, 16'd18});
        for (int i = 0; i < 20; i++) tick();
        chk("b2b_final", {busy, cap_word, match}, {1'b0, 16'h5A5A, 1'b1});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
